// File: rtl/skew_feeder.sv
// Operand skew feeder for an NxN systolic array: buffers up to KMAX A-column/B-row
// vectors, then streams them diagonally skewed on the west/north edges. Option: SKEW_FEEDER_REPLAY_EN.
module skew_feeder #(
  parameter int N     = 16,
  parameter int DW    = 32,
  parameter int KMAX  = 16,
  parameter int DRAIN = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [N*DW-1:0]            a_vec,
  input  logic [N*DW-1:0]            b_vec,
  input  logic                       start,
  output logic [N*DW-1:0]            west_o,
  output logic [N*DW-1:0]            north_o,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(KMAX+1)-1:0]  klen,
  output logic [1:0]                 o_dbg_state
);

  localparam int KW  = $clog2(KMAX+1);
  localparam int AW  = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int TW  = $clog2(KMAX+N+1);
  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

`ifdef SKEW_FEEDER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KW-1:0]    r_klen;
  logic [TW-1:0]    r_t;
  logic [DCW-1:0]   r_drain;
  logic [N*DW-1:0]  r_west;
  logic [N*DW-1:0]  r_north;
  logic [N*DW-1:0]  r_a_mem [KMAX];
  logic [N*DW-1:0]  r_b_mem [KMAX];

  logic             w_accept;
  logic             w_go;
  logic             w_last_t;
  logic             w_last_drain;
  logic             w_load;
  logic [TW-1:0]    w_tn;
  logic [TW-1:0]    w_klen_eff;
  logic [N*DW-1:0]  w_west_nxt;
  logic [N*DW-1:0]  w_north_nxt;

  // Handshake: a vector transfers on a rising edge where ld_valid && ld_ready.
  assign w_accept     = ld_valid && ld_ready;
  assign w_klen_eff   = TW'(r_klen) + TW'(w_accept);
  assign w_go         = (r_state == S_IDLE) && start && (w_klen_eff != '0);
  assign w_last_t     = (r_t == (TW'(r_klen) + TW'(N-2)));
  assign w_last_drain = (r_drain == DCW'(DRAIN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_go)         w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_t)     w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_last_drain) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:   ld_ready = (r_klen < KW'(KMAX));
      S_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN:  begin
        busy = 1'b1;
        done = w_last_drain;
      end
      default:  ld_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_klen  <= '0;
      r_t     <= '0;
      r_drain <= '0;
    end else begin
      if (w_accept)
        r_klen <= r_klen + KW'(1);
      else if (done && !REPLAY)
        r_klen <= '0;

      if (w_go)
        r_t <= '0;
      else if ((r_state == S_STREAM) && !w_last_t)
        r_t <= r_t + TW'(1);

      if ((r_state == S_STREAM) && w_last_t)
        r_drain <= '0;
      else if ((r_state == S_DRAIN) && !w_last_drain)
        r_drain <= r_drain + DCW'(1);
    end
  end

  // Operand buffer carries no reset; slots beyond klen are never read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_mem[r_klen[AW-1:0]] <= a_vec;
      r_b_mem[r_klen[AW-1:0]] <= b_vec;
    end
  end

  // Outputs are registered, so lanes are computed for the cycle being entered.
  assign w_load = w_go || ((r_state == S_STREAM) && !w_last_t);
  assign w_tn   = w_go ? '0 : (r_t + TW'(1));

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [TW-1:0] w_k;
    logic [AW-1:0] w_idx;
    logic          w_in;
    logic          w_byp;

    assign w_k   = w_tn - TW'(g);
    assign w_idx = w_k[AW-1:0];
    assign w_in  = w_load && (w_tn >= TW'(g)) && (w_k < w_klen_eff);
    // A vector loaded in the start cycle is not yet in the buffer.
    assign w_byp = w_accept && (w_k == TW'(r_klen));

    assign w_west_nxt[g*DW +: DW]  = !w_in ? '0 :
                                     (w_byp ? a_vec[g*DW +: DW] : r_a_mem[w_idx][g*DW +: DW]);
    assign w_north_nxt[g*DW +: DW] = !w_in ? '0 :
                                     (w_byp ? b_vec[g*DW +: DW] : r_b_mem[w_idx][g*DW +: DW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_west  <= '0;
      r_north <= '0;
    end else begin
      r_west  <= w_west_nxt;
      r_north <= w_north_nxt;
    end
  end

  assign west_o      = r_west;
  assign north_o     = r_north;
  assign klen        = r_klen;
  assign o_dbg_state = r_state;

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter N, default 16: array edge size, i.e. the number of west lanes and north lanes.
REQ-002 Parameter DW, default 32: element width in bits.
REQ-003 Parameter KMAX, default 16: maximum inner-dimension length, i.e. buffer depth in vectors.
REQ-004 Parameter DRAIN, default 32: number of zero-fill cycles after streaming, letting the array finish.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ld_valid  in  1  load vector k is present on a_vec/b_vec.
REQ-008 ld_ready  out  1  feeder accepts a vector this cycle.
REQ-009 a_vec  in  N*DW  column k of A; lane i = A[i][k] at [i*DW +: DW].
REQ-010 b_vec  in  N*DW  row k of B; lane j = B[k][j] at [j*DW +: DW].
REQ-011 start  in  1  single-cycle request to begin streaming.
REQ-012 west_o  out  N*DW  skewed west-edge data; lane i drives array west row i.
REQ-013 north_o  out  N*DW  skewed north-edge data; lane j drives array north column j.
REQ-014 out_valid  out  1  high during the STREAM state only.
REQ-015 busy  out  1  high in STREAM and DRAIN.
REQ-016 done  out  1  one-cycle pulse on the last DRAIN cycle.
REQ-017 klen  out  clog2(KMAX+1)  number of vectors currently buffered.

Function
REQ-018 States SHALL be IDLE, STREAM, DRAIN; loading happens only in IDLE.
REQ-019 A vector SHALL be accepted when ld_valid && ld_ready, written to buffer slot klen, and klen SHALL increment by 1.
REQ-020 ld_ready SHALL be 1 only in IDLE with klen < KMAX; ld_valid while ld_ready=0 is ignored.
REQ-021 start SHALL move IDLE->STREAM only if klen >= 1; start with klen=0, or start in STREAM/DRAIN, is ignored.
REQ-022 If start and an accepted load occur in the same cycle, the load SHALL be included and streaming SHALL use klen+1.
REQ-023 STREAM SHALL last exactly klen+N-1 cycles; let t = 0 be the first STREAM cycle.
REQ-024 In STREAM cycle t: west lane i = A[i][t-i] if 0 <= t-i < klen, else 0; north lane j = B[t-j][j] if 0 <= t-j < klen, else 0.
REQ-025 Outputs SHALL be registered; first STREAM cycle = cycle after start is sampled.
REQ-026 The feeder SHALL enter DRAIN after STREAM, drive all lanes 0 for DRAIN cycles, pulse done on the final DRAIN cycle, then return to IDLE.
REQ-027 Outside STREAM, west_o and north_o SHALL be all zeros.
REQ-028 The feeder SHALL pass data unmodified with no arithmetic; counters SHALL saturate and never wrap.

Reset
REQ-029 When rst_n is low, regardless of clk: state=IDLE, klen=0, west_o=0, north_o=0, out_valid=0, busy=0, done=0; ld_ready=1 once state=IDLE.
REQ-030 Reset asserted mid-STREAM or mid-DRAIN SHALL abort immediately with no done pulse; buffer contents are don't-care.
REQ-031 Buffer RAM SHALL not require reset.

Configuration
REQ-032 Macro SKEW_FEEDER_REPLAY_EN: when defined, klen is retained on return to IDLE, so a new start replays the same operands and further loads append.
REQ-033 Without SKEW_FEEDER_REPLAY_EN, klen SHALL clear to 0 in the cycle done pulses.

Verification
REQ-034 N=16, load 16 vectors with A[i][k]=i*16+k and B[k][j]=k*16+j, then start -> 31 out_valid cycles; t=0: west0=0, north0=0, others 0; t=15: west15=240; t=30: west15=255, north15=255; then 32 zero cycles, done pulse, busy low.
REQ-035 Load 3 vectors, start -> STREAM 18 cycles; west0 nonzero only t=0..2; west15 only t=15..17.
REQ-036 Start with klen=0 -> no state change, busy stays 0; 17th ld_valid after 16 loads -> ld_ready=0, klen stays 16.
REQ-037 Deassert rst_n at STREAM t=5 -> all outputs 0 asynchronously, klen=0, no done; after release, new load/start works normally.
REQ-038 With SKEW_FEEDER_REPLAY_EN: load 2, stream, done, start again -> identical output sequence; without it -> second start is ignored (klen=0).
